// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with leading-zero blanking and overflow blanking for seven-segment decoders.
module bin_to_bcd_seq #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int unsigned SW = 4*DIGITS + 4;
   localparam int unsigned CW = $clog2(BIN_W + 1);

   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_n;
   logic [SW-1:0]       scratch, scratch_n;
   logic [BIN_W-1:0]    shreg, shreg_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                blank, blank_n;
   logic                ovf, ovf_n;
   logic                done_n;
   logic [4*DIGITS-1:0] bcd_n;
   logic                overflow_n;

   logic [SW-1:0]       adj;
   logic [SW-1:0]       nxt;
   logic [4*DIGITS-1:0] fmt;
   logic                lead;

   assign busy = (state == SHIFT);

   always_comb begin
      adj = '0;
      for (int unsigned i = 0; i < DIGITS + 1; i++) begin
         adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                      : scratch[4*i +: 4];
      end
      // top bit of the spare nibble falls off; it only matters when ovf blanks the result
      nxt = SW'({adj, shreg[BIN_W-1]});

      fmt  = '1;
      lead = blank;
      for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
         if (lead && (nxt[4*(DIGITS-1-j) +: 4] == 4'd0)) begin
            fmt[4*(DIGITS-1-j) +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
            fmt[4*(DIGITS-1-j) +: 4] = nxt[4*(DIGITS-1-j) +: 4];
         end
      end
      fmt[3:0] = nxt[3:0];
      if (ovf) fmt = '1;
   end

   always_comb begin
      state_n    = state;
      scratch_n  = scratch;
      shreg_n    = shreg;
      cnt_n      = cnt;
      blank_n    = blank;
      ovf_n      = ovf;
      done_n     = 1'b0;
      bcd_n      = bcd;
      overflow_n = overflow;
      case (state)
         IDLE: begin
            if (start) begin
               state_n   = SHIFT;
               shreg_n   = bin;
               blank_n   = blank_lz;
               ovf_n     = (64'(bin) >= LIMIT);
               scratch_n = '0;
               cnt_n     = CW'(BIN_W);
            end
         end
         SHIFT: begin
            scratch_n = nxt;
            shreg_n   = shreg << 1;
            cnt_n     = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n    = IDLE;
               done_n     = 1'b1;
               bcd_n      = fmt;
               overflow_n = ovf;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         scratch  <= '0;
         shreg    <= '0;
         cnt      <= '0;
         blank    <= 1'b0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         bcd      <= '1;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         scratch  <= scratch_n;
         shreg    <= shreg_n;
         cnt      <= cnt_n;
         blank    <= blank_n;
         ovf      <= ovf_n;
         done     <= done_n;
         bcd      <= bcd_n;
         overflow <= overflow_n;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed plus randomized checks of bin_to_bcd_seq (BIN_W=14, DIGITS=4)
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        blank_lz = 1'b0;
   logic        busy, done, overflow;
   logic [15:0] bcd;

   int vectors = 0;
   int errors  = 0;

   bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .blank_lz(blank_lz),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_bcd(int unsigned v, bit blz);
      logic [15:0] r;
      bit          lead;
      int unsigned d;
      if (v >= 10000) return 16'hFFFF;
      lead = blz;
      r    = '0;
      for (int k = 3; k >= 0; k--) begin
         d = (v / (10 ** k)) % 10;
         if (lead && d == 0 && k != 0) r[4*k +: 4] = 4'hF;
         else begin
            lead = 1'b0;
            r[4*k +: 4] = 4'(d);
         end
      end
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from the launch edge until done is seen (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            bin   = 14'($urandom);
            blank_lz = 1'($urandom);
            chk("busy_after_start", 32'(busy), 32'd1);
         end
      end while (!done && cyc < 40);
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic convert(string tag, int unsigned v, bit blz, bit check_lat);
      int cyc;
      start = 1'b1; bin = 14'(v); blank_lz = blz;
      wait_done(cyc);
      if (check_lat) chk({tag, "_latency"}, 32'(cyc - 1), 32'd14);
      chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v, blz)));
      chk({tag, "_ovf"}, 32'(overflow), 32'(v >= 10000));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int cyc, ndone, v;
      bit b;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd",  32'(bcd),  32'hFFFF);
      chk("rst_ovf",  32'(overflow), 32'd0);

      convert("d1234",  1234,  1'b0, 1'b1);
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("bcd_hold", 32'(bcd), 32'h1234);
      convert("d42b",   42,    1'b1, 1'b1);
      convert("d42",    42,    1'b0, 1'b1);
      convert("d0b",    0,     1'b1, 1'b1);
      convert("d0",     0,     1'b0, 1'b0);
      convert("d9999",  9999,  1'b1, 1'b1);
      convert("d10000", 10000, 1'b0, 1'b1);
      convert("d16383", 16383, 1'b1, 1'b1);
      convert("d100b",  100,   1'b1, 1'b0);

      // starts during a conversion are ignored
      start = 1'b1; bin = 14'd321; blank_lz = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (done) begin
            ndone++;
            chk("ign_latency", 32'(c - 1), 32'd14);
         end
         start = (c == 3 || c == 7);
         bin   = 14'd9999;
      end
      chk("ign_ndone", 32'(ndone), 32'd1);
      chk("ign_bcd", 32'(bcd), 32'h0321);

      // back-to-back: start in the done cycle
      convert("b2b_a", 88, 1'b0, 1'b1);
      start = 1'b1; bin = 14'd5; blank_lz = 1'b1;
      wait_done(cyc);
      chk("b2b_spacing", 32'(cyc), 32'd15);
      chk("b2b_bcd", 32'(bcd), 32'hFFF5);

      // reset mid-conversion aborts
      start = 1'b1; bin = 14'd1234; blank_lz = 1'b0;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'hFFFF);
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      convert("d777b", 777, 1'b1, 1'b1);

      // rst wins over start
      rst = 1'b1; start = 1'b1; bin = 14'd55;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_prio_busy", 32'(busy), 32'd0);
      chk("rst_prio_bcd", 32'(bcd), 32'hFFFF);

      for (int i = 0; i < 30; i++) begin
         v = (i % 5 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
         b = 1'($urandom);
         convert("rand", v, b, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
